// File: rtl/pool_window_gather_if.sv
// ----------------------------------------------------------------------------
// pool_window_gather_if
//
// Bundle of the sample stream, configuration and pooling-window outputs of
// pool_window_gather. The clock and reset stay plain ports on the block.
//
//   Conv_OData      signed 16-bit convolution sample
//   Conv_OData_vld  sample valid, one sample per high cycle
//   Line_end        last sample of a line (qualified by Conv_OData_vld)
//   Shift           right-shift amount applied after ReLU, 0..15
//   P               pool size, legal values 2, 4, 5, 7
//   Clear           synchronous clear of Win_cnt and Cfg_err
//   Pool_IData      packed 7 x 8-bit window, lane k = (k+1)-th sample
//   Pool_IData_vld  one-cycle pulse, Pool_IData valid
//   Win_cnt         emitted-window counter, wraps at 2^16
//   Cfg_err         sticky illegal-pool-size flag
//
// master: the side producing samples (testbench / conv stage)
// slave : pool_window_gather itself
// ----------------------------------------------------------------------------
interface pool_window_gather_if;
    logic signed [15:0] Conv_OData;
    logic               Conv_OData_vld;
    logic               Line_end;
    logic [3:0]         Shift;
    logic [2:0]         P;
    logic               Clear;
    logic [55:0]        Pool_IData;
    logic               Pool_IData_vld;
    logic [15:0]        Win_cnt;
    logic               Cfg_err;

    modport master (
        output Conv_OData, Conv_OData_vld, Line_end, Shift, P, Clear,
        input  Pool_IData, Pool_IData_vld, Win_cnt, Cfg_err
    );

    modport slave (
        input  Conv_OData, Conv_OData_vld, Line_end, Shift, P, Clear,
        output Pool_IData, Pool_IData_vld, Win_cnt, Cfg_err
    );
endinterface

// File: rtl/pool_window_gather.sv
// ----------------------------------------------------------------------------
// pool_window_gather
//
// Front end of the ReLU / max-pool path. Each accepted sample is rectified,
// arithmetically right-shifted by Shift and saturated to 0..127 (stage 1),
// then packed into a 7-lane window of P samples (stage 2). A window closes
// when P samples have been collected or when a sample carries Line_end;
// unwritten lanes stay 0, which is neutral for max pooling of data >= 0.
// An illegal pool size at window start sets Cfg_err and discards samples
// up to and including the next Line_end.
//
// Ports:
//   clk_cal  calculation clock, all state on the rising edge
//   rst_cal  asynchronous, active-high reset
//   bus      pool_window_gather_if.slave (sample stream, config, window out)
//
// Latency: last sample of a window captured at edge t -> Pool_IData_vld high
// in the cycle following edge t+1.
// ----------------------------------------------------------------------------
module pool_window_gather (
    input  logic                  clk_cal,
    input  logic                  rst_cal,
    pool_window_gather_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // cnt == 0, next sample starts a window
        ST_FILL = 2'd1,   // 0 < cnt < p_win
        ST_DROP = 2'd2    // illegal P latched, waiting for Line_end
    } state_t;

    function automatic logic p_is_legal(input logic [2:0] p);
        return (p == 3'd2) || (p == 3'd4) || (p == 3'd5) || (p == 3'd7);
    endfunction

    // ------------------------------------------------------------------------
    // Stage 1: ReLU, shift, saturate
    // ------------------------------------------------------------------------
    logic [15:0] relu_w;
    logic [15:0] shifted_w;
    logic [7:0]  q_d;

    always_comb begin
        // NOTE: every combinational output gets a value on every path;
        // a missing default would infer a latch.
        relu_w    = bus.Conv_OData[15] ? 16'd0 : $unsigned(bus.Conv_OData);
        // relu_w is non-negative, so a logical shift equals the arithmetic one.
        shifted_w = relu_w >> bus.Shift;
        q_d       = (shifted_w > 16'd127) ? 8'd127 : shifted_w[7:0];
    end

    logic       s1_vld_q;
    logic [7:0] s1_data_q;
    logic       s1_last_q;
    logic [2:0] s1_p_q;

    // P travels with the sample so the window size seen by stage 2 is the
    // one present when the window's first sample arrived.
    always_ff @(posedge clk_cal or posedge rst_cal) begin
        // NOTE: state registers use non-blocking assignments so every
        // always_ff block samples the pre-edge values of the others.
        if (rst_cal) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= 8'd0;
            s1_last_q <= 1'b0;
            s1_p_q    <= 3'd0;
        end else begin
            s1_vld_q <= bus.Conv_OData_vld;
            if (bus.Conv_OData_vld) begin
                s1_data_q <= q_d;
                s1_last_q <= bus.Line_end;
                s1_p_q    <= bus.P;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: window packing
    // ------------------------------------------------------------------------
    state_t          state_q;
    logic [2:0]      cnt_q;
    logic [2:0]      p_win_q;
    logic [6:0][7:0] lanes_q;
    logic [55:0]     pool_data_q;
    logic            pool_vld_q;
    logic [15:0]     win_cnt_q;
    logic            cfg_err_q;

    logic            start_legal_w;
    logic            last_lane_w;
    logic            complete_w;
    logic            bad_start_w;
    logic [6:0][7:0] window_w;

    always_comb begin
        start_legal_w = p_is_legal(s1_p_q);
        last_lane_w   = (cnt_q == 3'(p_win_q - 3'd1));

        // Working lanes with the current sample merged in; in IDLE all lanes
        // are zero and cnt is 0, so this is also the 1-sample window.
        window_w        = lanes_q;
        window_w[cnt_q] = s1_data_q;

        complete_w  = 1'b0;
        bad_start_w = 1'b0;
        if (s1_vld_q) begin
            unique case (state_q)
                ST_IDLE: begin
                    complete_w  = start_legal_w && s1_last_q;
                    bad_start_w = !start_legal_w;
                end
                ST_FILL: complete_w = s1_last_q || last_lane_w;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_cal or posedge rst_cal) begin
        // NOTE: the lane array is only seven bytes of flops, so it is reset
        // like any other register; "lanes not written hold 0" relies on it.
        if (rst_cal) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            p_win_q     <= 3'd0;
            lanes_q     <= '0;
            pool_data_q <= 56'd0;
            pool_vld_q  <= 1'b0;
            win_cnt_q   <= 16'd0;
            cfg_err_q   <= 1'b0;
        end else begin
            pool_vld_q <= complete_w;

            if (complete_w) begin
                pool_data_q <= window_w;
                lanes_q     <= '0;
                cnt_q       <= 3'd0;
                state_q     <= ST_IDLE;
            end else if (s1_vld_q) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (start_legal_w) begin
                            p_win_q    <= s1_p_q;
                            lanes_q[0] <= s1_data_q;
                            cnt_q      <= 3'd1;
                            state_q    <= ST_FILL;
                        end else if (!s1_last_q) begin
                            state_q <= ST_DROP;
                        end
                    end
                    ST_FILL: begin
                        lanes_q[cnt_q] <= s1_data_q;
                        cnt_q          <= cnt_q + 3'd1;
                    end
                    ST_DROP: begin
                        if (s1_last_q) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // The increment lines up with the edge that raises Pool_IData_vld.
            if (bus.Clear) begin
                win_cnt_q <= 16'd0;
            end else if (complete_w) begin
                win_cnt_q <= win_cnt_q + 16'd1;
            end

            if (bus.Clear) begin
                cfg_err_q <= 1'b0;
            end else if (bad_start_w) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    assign bus.Pool_IData     = pool_data_q;
    assign bus.Pool_IData_vld = pool_vld_q;
    assign bus.Win_cnt        = win_cnt_q;
    assign bus.Cfg_err        = cfg_err_q;

endmodule

// File: tb/tb_pool_window_gather.sv
// ----------------------------------------------------------------------------
// tb_pool_window_gather
//
// Directed bench for pool_window_gather. Inputs change 1 ns after a rising
// edge and outputs are compared at that same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_pool_window_gather;

    logic clk_cal = 1'b0;
    logic rst_cal = 1'b1;

    pool_window_gather_if bus_if ();

    pool_window_gather dut (
        .clk_cal (clk_cal),
        .rst_cal (rst_cal),
        .bus     (bus_if)
    );

    always #5 clk_cal = ~clk_cal;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_cal);
        #1;
    endtask

    task automatic send(input int v, input logic last);
        bus_if.Conv_OData     = 16'(v);
        bus_if.Conv_OData_vld = 1'b1;
        bus_if.Line_end       = last;
        step();
    endtask

    task automatic idle();
        bus_if.Conv_OData_vld = 1'b0;
        bus_if.Line_end       = 1'b0;
        step();
    endtask

    function automatic logic [55:0] win(input int a0, input int a1, input int a2,
                                        input int a3, input int a4, input int a5,
                                        input int a6);
        return {8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    initial begin
        bus_if.Conv_OData     = '0;
        bus_if.Conv_OData_vld = 1'b0;
        bus_if.Line_end       = 1'b0;
        bus_if.Shift          = 4'd0;
        bus_if.P              = 3'd4;
        bus_if.Clear          = 1'b0;

        // ---------------- reset values ----------------
        step();
        step();
        check("rst_data",  bus_if.Pool_IData,     64'd0);
        check("rst_vld",   bus_if.Pool_IData_vld, 64'd0);
        check("rst_wcnt",  bus_if.Win_cnt,        64'd0);
        check("rst_err",   bus_if.Cfg_err,        64'd0);
        rst_cal = 1'b0;

        // ---------------- P=4, Shift=0: 5, -3, 200, 17 ----------------
        send(5, 0);
        send(-3, 0);
        send(200, 0);
        send(17, 0);
        check("p4_early_vld", bus_if.Pool_IData_vld, 64'd0);
        idle();
        check("p4_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("p4_data", bus_if.Pool_IData, win(8'h05, 8'h00, 8'h7F, 8'h11, 0, 0, 0));
        check("p4_wcnt", bus_if.Win_cnt, 64'd1);
        idle();
        check("p4_pulse_end", bus_if.Pool_IData_vld, 64'd0);
        check("p4_hold",      bus_if.Pool_IData, win(8'h05, 8'h00, 8'h7F, 8'h11, 0, 0, 0));

        // ---------------- saturation boundaries ----------------
        // 127 -> 127, 128 -> 127 (saturate), -32768 -> 0, then Shift=8: 32767>>8=127
        send(127, 0);
        send(128, 0);
        send(-32768, 0);
        bus_if.Shift = 4'd8;
        send(32767, 0);
        idle();
        check("sat_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("sat_data", bus_if.Pool_IData, win(127, 127, 0, 127, 0, 0, 0));
        check("sat_wcnt", bus_if.Win_cnt, 64'd2);

        // ---------------- Clear ----------------
        bus_if.Clear = 1'b1;
        step();
        bus_if.Clear = 1'b0;
        check("clr_wcnt", bus_if.Win_cnt, 64'd0);

        // ---------------- P=7, Shift=2, 14 samples 4..56 ----------------
        bus_if.P     = 3'd7;
        bus_if.Shift = 4'd2;
        for (int k = 1; k <= 14; k++) begin
            send(4 * k, 0);
            // the pulse for sample k-1 is visible right after sample k is taken
            check($sformatf("p7_vld_k%0d", k), bus_if.Pool_IData_vld, (k == 8) ? 64'd1 : 64'd0);
            if (k == 8) begin
                check("p7_win1", bus_if.Pool_IData, win(1, 2, 3, 4, 5, 6, 7));
            end
        end
        idle();
        check("p7_vld2",  bus_if.Pool_IData_vld, 64'd1);
        check("p7_win2",  bus_if.Pool_IData, win(8, 9, 10, 11, 12, 13, 14));
        check("p7_wcnt",  bus_if.Win_cnt, 64'd2);

        // ---------------- P=5, Line_end on 3rd sample ----------------
        bus_if.P     = 3'd5;
        bus_if.Shift = 4'd0;
        send(9, 0);
        send(10, 0);
        send(11, 1);
        idle();
        check("le_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("le_data", bus_if.Pool_IData, win(9, 10, 11, 0, 0, 0, 0));
        // next window starts again at lane 0
        send(20, 0);
        send(21, 1);
        idle();
        check("le2_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("le2_data", bus_if.Pool_IData, win(20, 21, 0, 0, 0, 0, 0));
        check("le_wcnt",  bus_if.Win_cnt, 64'd4);

        // ---------------- P changes 2 -> 7 after first sample ----------------
        bus_if.P = 3'd2;
        send(1, 0);
        bus_if.P = 3'd7;
        send(2, 0);
        idle();
        check("pchg_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("pchg_data", bus_if.Pool_IData, win(1, 2, 0, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) begin
            send(30 + k, 0);
        end
        check("pchg7_early", bus_if.Pool_IData_vld, 64'd0);
        idle();
        check("pchg7_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("pchg7_data", bus_if.Pool_IData, win(30, 31, 32, 33, 34, 35, 36));
        check("pchg_wcnt",  bus_if.Win_cnt, 64'd6);

        // ---------------- illegal P=3 ----------------
        bus_if.P = 3'd3;
        send(1, 0);
        idle();
        check("ill_err", bus_if.Cfg_err, 64'd1);
        send(2, 0);
        send(3, 1);
        check("ill_vld_a", bus_if.Pool_IData_vld, 64'd0);
        bus_if.P = 3'd2;
        idle();
        check("ill_vld_b", bus_if.Pool_IData_vld, 64'd0);
        send(4, 0);
        send(5, 0);
        idle();
        check("ill_rec_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("ill_rec_data", bus_if.Pool_IData, win(4, 5, 0, 0, 0, 0, 0));
        check("ill_wcnt",     bus_if.Win_cnt, 64'd7);
        bus_if.Clear = 1'b1;
        step();
        bus_if.Clear = 1'b0;
        check("ill_clr_err", bus_if.Cfg_err, 64'd0);

        // ---------------- asynchronous reset mid-window ----------------
        send(8, 0);
        send(9, 0);
        idle();
        check("pre_rst_wcnt", bus_if.Win_cnt, 64'd1);
        bus_if.P = 3'd7;
        send(1, 0);
        send(2, 0);
        send(3, 0);
        bus_if.Conv_OData_vld = 1'b0;
        #2;
        rst_cal = 1'b1;
        #1;
        check("arst_data", bus_if.Pool_IData, 64'd0);
        check("arst_wcnt", bus_if.Win_cnt,    64'd0);
        check("arst_vld",  bus_if.Pool_IData_vld, 64'd0);
        check("arst_err",  bus_if.Cfg_err,    64'd0);
        step();
        rst_cal = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            send(10 * k, 0);
        end
        check("post_rst_early", bus_if.Pool_IData_vld, 64'd0);
        idle();
        check("post_rst_vld",  bus_if.Pool_IData_vld, 64'd1);
        check("post_rst_data", bus_if.Pool_IData, win(10, 20, 30, 40, 50, 60, 70));
        check("post_rst_wcnt", bus_if.Win_cnt, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
